// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and bus widths for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int INST_ADDR_SIZE = 64;
  localparam int DATA_BUS       = 64;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CMD  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_t;

  function automatic logic [31:0] word_sel(input logic [63:0] dw, input logic hi);
    return hi ? dw[63:32] : dw[31:0];
  endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating count of consecutive fetch losses; at_max forces the next fetch grant.
// Clear has priority over increment.
module arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] r_cnt;
  logic          w_at_max;

  assign w_at_max = (r_cnt == CW'(STARVE_MAX));
  assign o_at_max = w_at_max;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_at_max) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and load/store, data-first with fetch anti-starvation.
// One transaction in flight; owner rvalid 3 cycles after accept on zero-wait memory; requesters hold req until ready.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = INST_ADDR_SIZE,
  parameter int DATA_W     = DATA_BUS,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ready,
  output logic                if_rvalid,
  output logic [31:0]         if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wmask,
  output logic                d_ready,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  arb_state_t          r_state, w_next;
  arb_owner_t          r_owner;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wmask;
  logic                r_word_hi;
  logic                r_if_rvalid, r_d_rvalid;
  logic [31:0]         r_if_rdata;
  logic [DATA_W-1:0]   r_d_rdata;

  logic w_grant_if, w_grant_d, w_done, w_inc, w_clr, w_at_max, w_cmd;
  logic w_unused;

  assign w_unused = ^{if_addr[1:0], d_addr[2:0]};

  arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk      (clk),
    .rst      (rst),
    .i_inc    (w_inc),
    .i_clr    (w_clr),
    .o_at_max (w_at_max)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ARB_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_grant_if = 1'b0;
    w_grant_d  = 1'b0;
    w_inc      = 1'b0;
    w_clr      = 1'b0;
    w_done     = 1'b0;
    mem_req    = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        // Fetch only loses to a pending data request until it has lost STARVE_MAX times.
        if (if_req && (!d_req || w_at_max)) begin
          w_grant_if = 1'b1;
          w_clr      = 1'b1;
          w_next     = ARB_CMD;
        end else if (d_req) begin
          w_grant_d = 1'b1;
          w_inc     = if_req;
          w_next    = ARB_CMD;
        end
      end
      ARB_CMD: begin
        mem_req = 1'b1;
        if (mem_gnt) begin
          if (mem_rvalid) begin
            w_done = 1'b1;
            w_next = ARB_IDLE;
          end else begin
            w_next = ARB_RESP;
          end
        end
      end
      ARB_RESP: begin
        if (mem_rvalid) begin
          w_done = 1'b1;
          w_next = ARB_IDLE;
        end
      end
      default: w_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_owner     <= OWN_IF;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_wmask     <= '0;
      r_word_hi   <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      if (w_grant_if) begin
        r_owner   <= OWN_IF;
        r_addr    <= {if_addr[ADDR_W-1:3], 3'b000};
        r_we      <= 1'b0;
        r_wdata   <= '0;
        r_wmask   <= '0;
        r_word_hi <= if_addr[2];
      end else if (w_grant_d) begin
        r_owner   <= OWN_D;
        r_addr    <= {d_addr[ADDR_W-1:3], 3'b000};
        r_we      <= d_we;
        r_wdata   <= d_wdata;
        r_wmask   <= d_we ? d_wmask : '0;
        r_word_hi <= 1'b0;
      end
      if (w_done) begin
        if (r_owner == OWN_IF) begin
          r_if_rvalid <= 1'b1;
          r_if_rdata  <= word_sel(mem_rdata, r_word_hi);
        end else begin
          r_d_rvalid <= 1'b1;
          if (!r_we) r_d_rdata <= mem_rdata;
        end
      end
    end
  end

  assign w_cmd     = (r_state == ARB_CMD);
  assign mem_we    = w_cmd & r_we;
  assign mem_addr  = w_cmd ? r_addr : '0;
  assign mem_wdata = w_cmd ? r_wdata : '0;
  assign mem_wmask = w_cmd ? r_wmask : '0;

  assign if_ready  = w_grant_if;
  assign d_ready   = w_grant_d;
  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign d_rvalid  = r_d_rvalid;
  assign d_rdata   = r_d_rdata;
  assign busy      = (r_state != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: requester queues, a delay-configurable memory model and a response scoreboard.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [63:0] if_addr = '0;
  logic        if_ready, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [63:0] d_addr = '0, d_wdata = '0;
  logic [7:0]  d_wmask = '0;
  logic        d_ready, d_rvalid;
  logic [63:0] d_rdata;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic        busy;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
  );

  typedef struct { logic is_d; logic we; logic [63:0] addr; logic [63:0] wdata; logic [7:0] wmask; } req_t;
  typedef struct { logic is_d; logic [63:0] data; } exp_t;
  typedef struct {
    logic is_d; logic we; logic [63:0] addr; logic [63:0] wdata; logic [7:0] wmask;
    int gnt_dly; int rv_dly; int exp_lat; int exp_req; logic chk_data; logic [63:0] exp_data;
  } vec_t;

  int n_chk = 0, n_fail = 0, cyc = 0;
  req_t if_q[$], d_q[$];
  exp_t sb[$];
  logic grant_log[$];
  logic [63:0] last_load = '0, last_rv_data = '0;
  logic in_flight = 1'b0;
  logic        c_we;
  logic [63:0] c_addr, c_wdata;
  logic [7:0]  c_wmask;
  int acc_cyc = 0, rv_cyc = 0, req_cyc_cnt = 0, rv_pulses = 0;
  logic mem_auto = 1'b1;
  int gnt_dly = 0, rv_dly = 1, m_phase = 0, m_cnt = 0;
  logic [63:0] m_addr = '0;

  function automatic logic [63:0] pat(input logic [63:0] a);
    if (a == 64'h0000_0000_8000_0000) return 64'h00B5_0513_0000_0013;
    return {a[31:0] ^ 32'hC0DE_0000, ~a[31:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_if(input logic [63:0] a);
    req_t r;
    r.is_d = 1'b0; r.we = 1'b0; r.addr = a; r.wdata = '0; r.wmask = '0;
    if_q.push_back(r);
  endtask

  task automatic push_d(input logic we, input logic [63:0] a, input logic [63:0] wd, input logic [7:0] wm);
    req_t r;
    r.is_d = 1'b1; r.we = we; r.addr = a; r.wdata = wd; r.wmask = wm;
    d_q.push_back(r);
  endtask

  task automatic mem_drive();
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    if (m_phase == 2) begin
      if (m_cnt <= 1) begin
        mem_rvalid = 1'b1; mem_rdata = pat(m_addr); m_phase = 0;
      end else m_cnt--;
    end else begin
      if (m_phase == 0 && mem_req) begin m_phase = 1; m_cnt = gnt_dly; end
      if (m_phase == 1) begin
        if (m_cnt == 0) begin
          mem_gnt = 1'b1; m_addr = mem_addr;
          if (rv_dly == 0) begin mem_rvalid = 1'b1; mem_rdata = pat(mem_addr); m_phase = 0; end
          else begin m_phase = 2; m_cnt = rv_dly; end
        end else m_cnt--;
      end
    end
  endtask

  task automatic sample();
    exp_t e;
    req_t r;
    logic [63:0] al, p;
    check("one_ready", 64'(if_ready & d_ready), 64'd0);
    check("one_rvalid", 64'(if_rvalid & d_rvalid), 64'd0);
    if (if_rvalid || d_rvalid) begin
      rv_pulses++; rv_cyc = cyc; in_flight = 1'b0;
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL spurious_rvalid: if_rvalid=%0b d_rvalid=%0b, expected none (cycle %0d)", if_rvalid, d_rvalid, cyc);
      end else begin
        e = sb.pop_front();
        check("rvalid_owner", 64'(d_rvalid), 64'(e.is_d));
        if (e.is_d) begin check("d_rdata", d_rdata, e.data); last_rv_data = d_rdata; end
        else begin check("if_rdata", 64'(if_rdata), e.data); last_rv_data = 64'(if_rdata); end
      end
    end
    check("busy", 64'(busy), 64'(in_flight));
    if (mem_req) begin
      req_cyc_cnt++;
      check("mem_addr", mem_addr, c_addr);
      check("mem_we", 64'(mem_we), 64'(c_we));
      check("mem_wmask", 64'(mem_wmask), 64'(c_wmask));
      if (c_we) check("mem_wdata", mem_wdata, c_wdata);
    end
    if (if_ready) begin
      if (if_q.size() == 0) begin
        n_chk++; n_fail++; $display("FAIL spurious_if_ready: got 1, expected 0 (cycle %0d)", cyc);
      end else begin
        r = if_q.pop_front();
        al = {r.addr[63:3], 3'b000}; p = pat(al);
        e.is_d = 1'b0; e.data = r.addr[2] ? {32'h0, p[63:32]} : {32'h0, p[31:0]};
        sb.push_back(e);
        c_addr = al; c_we = 1'b0; c_wdata = '0; c_wmask = '0;
        in_flight = 1'b1; acc_cyc = cyc; req_cyc_cnt = 0; grant_log.push_back(1'b0);
      end
    end
    if (d_ready) begin
      if (d_q.size() == 0) begin
        n_chk++; n_fail++; $display("FAIL spurious_d_ready: got 1, expected 0 (cycle %0d)", cyc);
      end else begin
        r = d_q.pop_front();
        al = {r.addr[63:3], 3'b000};
        e.is_d = 1'b1;
        if (r.we) e.data = last_load;
        else begin e.data = pat(al); last_load = e.data; end
        sb.push_back(e);
        c_addr = al; c_we = r.we; c_wdata = r.wdata; c_wmask = r.we ? r.wmask : 8'h00;
        in_flight = 1'b1; acc_cyc = cyc; req_cyc_cnt = 0; grant_log.push_back(1'b1);
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk); #1;
    if (if_q.size() > 0) begin if_req = 1'b1; if_addr = if_q[0].addr; end
    else begin if_req = 1'b0; if_addr = '0; end
    if (d_q.size() > 0) begin
      d_req = 1'b1; d_we = d_q[0].we; d_addr = d_q[0].addr; d_wdata = d_q[0].wdata; d_wmask = d_q[0].wmask;
    end else begin
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wmask = '0;
    end
    if (mem_auto) mem_drive();
    @(negedge clk);
    cyc++;
    sample();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    if_q.delete(); d_q.delete(); sb.delete();
    in_flight = 1'b0; last_load = '0; m_phase = 0;
    repeat (n) cycle();
    rst = 1'b1;
  endtask

  task automatic check_zero(input string name);
    check(name, 64'(|{if_ready, if_rvalid, d_ready, d_rvalid, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, busy}), 64'd0);
    check({name, "_if_rdata"}, 64'(if_rdata), 64'd0);
    check({name, "_d_rdata"}, d_rdata, 64'd0);
  endtask

  task automatic drain(input int max);
    int k;
    k = 0;
    while ((if_q.size() > 0 || d_q.size() > 0 || sb.size() > 0 || in_flight) && k < max) begin
      cycle(); k++;
    end
    if (if_q.size() > 0 || d_q.size() > 0 || sb.size() > 0 || in_flight) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: %0d requests and %0d responses still pending after %0d cycles",
               if_q.size() + d_q.size(), sb.size(), max);
    end
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[9];
    logic exp_log[7];
    int p0;
    vt[0] = '{1'b0, 1'b0, 64'h8000_0004, 64'h0, 8'h00, 0, 1, 3, 1, 1'b1, 64'h0000_0000_00B5_0513};
    vt[1] = '{1'b0, 1'b0, 64'h8000_0000, 64'h0, 8'h00, 0, 1, 3, 1, 1'b1, 64'h0000_0000_0000_0013};
    vt[2] = '{1'b0, 1'b0, 64'h8000_0017, 64'h0, 8'h00, 0, 1, 3, 1, 1'b1, 64'h0000_0000_40DE_0010};
    vt[3] = '{1'b1, 1'b0, 64'h8000_1000, 64'h0, 8'h00, 0, 1, 3, 1, 1'b1, 64'h40DE_1000_7FFF_EFFF};
    vt[4] = '{1'b1, 1'b1, 64'h8000_2008, 64'hDEAD_BEEF, 8'h0F, 0, 1, 3, 1, 1'b1, 64'h40DE_1000_7FFF_EFFF};
    vt[5] = '{1'b1, 1'b0, 64'h8000_3000, 64'h0, 8'h00, 3, 3, 8, 4, 1'b1, 64'h40DE_3000_7FFF_CFFF};
    vt[6] = '{1'b0, 1'b0, 64'h8000_0044, 64'h0, 8'h00, 0, 0, 2, 1, 1'b1, 64'h0000_0000_40DE_0040};
    vt[7] = '{1'b1, 1'b1, 64'h8000_0100, 64'h0123_4567_89AB_CDEF, 8'hF0, 1, 2, 5, 2, 1'b0, 64'h0};
    vt[8] = '{1'b1, 1'b0, 64'h8000_0105, 64'h0, 8'h00, 0, 1, 3, 1, 1'b1, 64'h40DE_0100_7FFF_FEFF};

    do_reset(2);
    check_zero("reset");

    for (int i = 0; i < 9; i++) begin
      gnt_dly = vt[i].gnt_dly; rv_dly = vt[i].rv_dly;
      if (vt[i].is_d) push_d(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].wmask);
      else push_if(vt[i].addr);
      p0 = rv_pulses;
      drain(60);
      repeat (2) cycle();
      check($sformatf("vec%0d_latency", i), 64'(rv_cyc - acc_cyc), 64'(vt[i].exp_lat));
      check($sformatf("vec%0d_mem_req_cycles", i), 64'(req_cyc_cnt), 64'(vt[i].exp_req));
      check($sformatf("vec%0d_rvalid_pulses", i), 64'(rv_pulses - p0), 64'd1);
      if (vt[i].chk_data) check($sformatf("vec%0d_rdata", i), last_rv_data, vt[i].exp_data);
    end

    gnt_dly = 0; rv_dly = 1;
    grant_log.delete();
    push_d(1'b0, 64'h8000_1000, 64'h0, 8'h00);
    push_if(64'h8000_0004);
    drain(60);
    check("simul_grants", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() == 2) begin
      check("simul_first_is_data", 64'(grant_log[0]), 64'd1);
      check("simul_second_is_fetch", 64'(grant_log[1]), 64'd0);
    end

    grant_log.delete();
    exp_log = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 6; k++) push_d(1'b0, 64'h8000_4000 + 64'(8 * k), 64'h0, 8'h00);
    push_if(64'h8000_0008);
    drain(200);
    check("starve_grants", 64'(grant_log.size()), 64'd7);
    for (int k = 0; k < 7; k++)
      if (k < grant_log.size()) check($sformatf("starve_grant%0d", k), 64'(grant_log[k]), 64'(exp_log[k]));
    grant_log.delete();
    push_d(1'b0, 64'h8000_5000, 64'h0, 8'h00);
    push_if(64'h8000_000C);
    drain(60);
    if (grant_log.size() == 2) check("starve_cleared_data_first", 64'(grant_log[0]), 64'd1);
    else check("starve_cleared_grants", 64'(grant_log.size()), 64'd2);

    repeat (2) cycle();
    mem_auto = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    push_if(64'h8000_0004);
    cycle();
    check("mr_if_ready", 64'(if_ready), 64'd1);
    mem_gnt = 1'b1;
    cycle();
    check("mr_cmd_mem_req", 64'(mem_req), 64'd1);
    cycle();
    mem_gnt = 1'b0;
    check("mr_resp_busy", 64'(busy), 64'd1);
    check("mr_resp_no_mem_req", 64'(mem_req), 64'd0);
    p0 = rv_pulses;
    do_reset(1);
    check_zero("mr_reset");
    mem_rvalid = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    cycle();
    mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) cycle();
    check("mr_no_rvalid", 64'(rv_pulses - p0), 64'd0);
    check_zero("mr_idle");
    mem_auto = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between the instruction-fetch requester and the load/store requester, using a req/ready and rvalid handshake on each side.
- Sits between if_top/id_top and ram_top. It replaces the direct dual-port hookup so the core can later stall on memory contention.
- One transaction is outstanding at a time.
- Data accesses win by default; an anti-starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 64, address width of every port.
- DATA_W, 64, memory data width; the write mask is DATA_W/8 bits.
- STARVE_MAX, 4, number of consecutive fetch losses after which the fetch request wins.

Ports:
- clk  in  1  core clock; all logic is on posedge.
- rst  in  1  synchronous, active-low reset.
- if_req  in  1  fetch request; held stable until if_ready.
- if_addr  in  ADDR_W  fetch byte address; bits [1:0] are ignored.
- if_ready  out  1  one-cycle pulse: fetch request accepted.
- if_rvalid  out  1  one-cycle pulse: if_rdata is valid.
- if_rdata  out  32  fetched instruction.
- d_req  in  1  data request; held stable until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  store data, already lane-aligned.
- d_wmask  in  DATA_W/8  byte-lane write enables.
- d_ready  out  1  one-cycle pulse: data request accepted.
- d_rvalid  out  1  one-cycle pulse: load data valid, or store completed.
- d_rdata  out  DATA_W  load doubleword; unchanged on stores.
- mem_req  out  1  memory command valid.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  doubleword-aligned address ({addr[ADDR_W-1:3],3'b0}).
- mem_wdata  out  DATA_W  write data.
- mem_wmask  out  DATA_W/8  byte enables; all-zero on reads.
- mem_gnt  in  1  memory accepted the command this cycle.
- mem_rvalid  in  1  read data valid, or write acknowledge.
- mem_rdata  in  DATA_W  read data.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst==0 at posedge):
  - state = IDLE and starve_cnt = 0.
  - All outputs are 0, including the rdata registers.
  - Reset mid-transaction abandons the transaction; a later mem_rvalid is not forwarded.
- FSM states: IDLE, CMD, RESP.
- IDLE:
  - With any request pending, select an owner. Rule: fetch wins if !d_req, or if starve_cnt==STARVE_MAX; otherwise data wins.
  - Pulse the owner's ready combinationally in the same cycle.
  - Latch owner, aligned address, we, wdata and wmask, plus if_addr[2] for word select. Go to CMD.
  - Starvation counting: if both requests are present and data wins, starve_cnt increments, saturating at STARVE_MAX. starve_cnt is cleared whenever fetch is granted.
- CMD:
  - mem_req=1 and the command is driven from the latched registers.
  - mem_gnt=1 → RESP.
  - mem_gnt and mem_rvalid both 1 → complete directly, handled as the RESP completion below.
  - A mem_rvalid without mem_gnt in CMD is ignored.
- RESP:
  - mem_req=0. Wait for mem_rvalid.
  - On mem_rvalid, register the data and next cycle pulse the owner's rvalid for exactly one cycle:
    - fetch: if_rdata = latched bit2 ? mem_rdata[63:32] : mem_rdata[31:0].
    - load: d_rdata = mem_rdata.
    - store: d_rvalid pulses and d_rdata holds its previous value.
  - Return to IDLE in the same edge. A new request may be accepted in the cycle rvalid is output.
- Latency with zero-wait memory (mem_gnt in the first CMD cycle, mem_rvalid in the first RESP cycle):
  - accept at cycle N;
  - mem_req at N+1;
  - mem_rvalid at N+2;
  - owner rvalid at N+3.
- mem_rvalid in IDLE is ignored and counted by nothing.
- A request deasserted before its ready is not an error; it is simply not accepted.
- Never more than one of if_ready/d_ready is high in a cycle; likewise never more than one of if_rvalid/d_rvalid.

Decomposition:
- Shared defines file holds:
  - FSM state encodings (ARB_IDLE/ARB_CMD/ARB_RESP, 2 bits);
  - owner encoding (OWN_IF=0, OWN_D=1);
  - INST_ADDR_SIZE and DATA_BUS macros, reused from the existing defines.
- One natural sub-module, arb_starve_ctr: a saturating counter with inc/clr/at_max outputs, width $clog2(STARVE_MAX+1).
- FSM and datapath latches stay in the top.

Test Plan:
- Reset then fetch only: if_req=1, if_addr=0x80000004, memory returns 0x00B50513_00000013 → if_ready at cycle 0, mem_addr=0x80000000 at cycle 1, if_rvalid=1 with if_rdata=0x00B50513 at cycle 3.
- Simultaneous requests: d_req (load 0x80001000) and if_req both high → data granted first and if_ready=0 that cycle; fetch granted on the next IDLE.
- Starvation: d_req held high continuously with if_req high, STARVE_MAX=4 → four data grants, fetch on the fifth grant, starve_cnt then 0.
- Store: d_we=1, d_wmask=0x0F, d_wdata=0xDEADBEEF → mem_we=1 and mem_wmask=0x0F in CMD; d_rvalid pulses after the ack; d_rdata unchanged.
- Wait states: mem_gnt delayed 3 cycles, mem_rvalid delayed 2 → mem_req held 4 cycles with a stable command; busy=1 throughout; exactly one rvalid pulse.
- Reset mid-RESP: rst=0 for one cycle, then mem_rvalid=1 → no if_rvalid/d_rvalid; all outputs 0; state IDLE.
